sd_cic_decimator: RTL
=====================

Name: sd_cic_decimator

Overview:
Receive-side counterpart to the team's 1-bit sigma-delta modulator. Takes the 1-bit bitstream (1 = +full-scale, 0 = -full-scale) and recovers multi-bit PCM samples with a 3rd-order CIC (sinc3) decimator, decimation ratio R = 2^DECIM_LOG2. Results are delivered over a valid/ready output port, with a sticky overrun flag for samples the consumer misses.

Parameters:
DECIM_LOG2, 6, log2 of decimation ratio R (R=64 default); legal range 2..9.
OUT_WIDTH, 32, width of pcm_out; must be >= 3*DECIM_LOG2+2.

Ports:
filter_clock  in  1  system/bitstream clock; all logic on its rising edge.
reset  in  1  synchronous, active-high.
bit_in  in  1  sigma-delta bitstream bit.
bit_valid  in  1  qualifies bit_in; one bit consumed per cycle where high.
pcm_out  out  OUT_WIDTH  signed two's-complement decimated sample, sign-extended.
out_valid  out  1  pcm_out holds an unconsumed sample.
out_ready  in  1  consumer accepts the sample when out_valid && out_ready.
overrun  out  1  sticky: an unconsumed sample was overwritten.
overrun_clr  in  1  clears overrun (single-cycle pulse).

Behaviour:
- Reset: integrators, comb delays, phase counter, warm-up counter, pcm_out, out_valid and overrun all reset to 0. Reset applied mid-operation discards any pending sample and restarts warm-up.
- Internal width W = 3*DECIM_LOG2+2, signed. All integrator/comb arithmetic is modulo 2^W; wrap-around is intentional. No saturation anywhere.
- Input mapping: x = +1 if bit_in=1, else -1 (W-bit).
- Integrators, pipelined, updated only when bit_valid=1. Each update uses old register values: i1<=i1+x; i2<=i2+i1; i3<=i3+i2. Integrators hold when bit_valid=0.
- Phase counter (DECIM_LOG2 bits):
  - Increments on each bit_valid and wraps R-1 -> 0.
  - A tick is bit_valid && phase==R-1.
- Comb, evaluated combinationally on a tick using the current i3 (pre-update value): c1=i3-d1; c2=c1-d2; c3=c2-d3.
- On the tick edge: d1<=i3, d2<=c1, d3<=c2.
- Warm-up:
  - The first 3 ticks after reset only load the comb delays. Warm-up counter 0..3 saturates at 3.
  - The 4th and later ticks produce output.
- Output load, on a producing tick edge:
  - pcm_out <= sign-extended c3; out_valid<=1.
  - Latency: out_valid is high the cycle after the tick.
- Handshake:
  - The transfer occurs on an edge where out_valid && out_ready. out_valid clears unless a producing tick loads on that same edge, in which case out_valid stays 1 with the new data and overrun is not set.
  - pcm_out is stable while out_valid=1 and no producing tick occurs.
- Overrun: a producing tick while out_valid=1 and out_ready=0 overwrites pcm_out and sets overrun<=1.
  - overrun_clr clears the flag.
  - If a set and a clear coincide on the same edge, set wins.
- Range: steady DC all-ones gives +R^3, all-zeros gives -R^3. These are the full-scale extremes and are exactly representable in W bits.

Test Plan:
- Reset, then all-ones with bit_valid=1 continuously and out_ready=1 -> first out_valid the cycle after input bit 256 (4th tick). Every output = +262144. No output during the first 192 bits.
- Reset, then all-zeros -> first output after bit 256. All outputs = -262144.
- Alternating 1,0,1,0 -> after warm-up every output = 0. Then switch to all-ones -> output settles to +262144 within 3 outputs.
- bit_valid toggling 1,0,1,0 with all-ones -> outputs identical to the continuous case. Ticks occur every 128 cycles; integrators hold on idle cycles.
- out_ready=0 across two producing ticks -> overrun=1, pcm_out = newest sample. Pulse overrun_clr -> overrun=0. Ready and tick on the same edge -> out_valid stays 1, overrun stays 0.
- Assert reset for 1 cycle mid-window (bit 100 of a window) with out_valid=1 -> out_valid=0 and overrun=0 next cycle. The next output appears only after 4 further ticks (256 more bits).

Source files
------------

// File: rtl/sd_cic_decimator.sv
// Third-order CIC (sinc3) decimator for a 1-bit sigma-delta bitstream, ratio R = 2^DECIM_LOG2.
// Results leave through a single-entry valid/ready register with a sticky overrun flag.
module sd_cic_decimator #(
    parameter int DECIM_LOG2 = 6,
    parameter int OUT_WIDTH  = 32
) (
    input  logic                 filter_clock,
    input  logic                 reset,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic [OUT_WIDTH-1:0] pcm_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 overrun,
    input  logic                 overrun_clr
);
    localparam int W = 3 * DECIM_LOG2 + 2;

    logic signed [W-1:0]   i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    logic signed [W-1:0]   d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic signed [W-1:0]   x, c1, c2, c3;
    logic [DECIM_LOG2-1:0] phase_q, phase_d;
    logic [1:0]            warm_q, warm_d;
    logic [OUT_WIDTH-1:0]  pcm_q, pcm_d;
    logic                  valid_q, valid_d;
    logic                  overrun_q, overrun_d;
    logic                  tick, produce;

    always_comb begin
        x       = bit_in ? W'(1) : '1;
        tick    = bit_valid && (phase_q == {DECIM_LOG2{1'b1}});
        produce = tick && (warm_q == 2'd3);

        // Comb stage sees the integrator output from before this edge's update.
        c1 = i3_q - d1_q;
        c2 = c1 - d2_q;
        c3 = c2 - d3_q;

        i1_d      = i1_q;
        i2_d      = i2_q;
        i3_d      = i3_q;
        d1_d      = d1_q;
        d2_d      = d2_q;
        d3_d      = d3_q;
        phase_d   = phase_q;
        warm_d    = warm_q;
        pcm_d     = pcm_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;

        if (bit_valid) begin
            i1_d    = i1_q + x;
            i2_d    = i2_q + i1_q;
            i3_d    = i3_q + i2_q;
            phase_d = phase_q + 1'b1;
        end

        if (tick) begin
            d1_d = i3_q;
            d2_d = c1;
            d3_d = c2;
            if (warm_q != 2'd3) begin
                warm_d = warm_q + 2'd1;
            end
        end

        // A load on the same edge as a transfer keeps the register full.
        if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
        if (produce) begin
            valid_d = 1'b1;
            pcm_d   = OUT_WIDTH'(c3);
        end

        if (overrun_clr) begin
            overrun_d = 1'b0;
        end
        if (produce && valid_q && !out_ready) begin
            overrun_d = 1'b1;
        end
    end

    always_ff @(posedge filter_clock) begin
        if (reset) begin
            i1_q      <= '0;
            i2_q      <= '0;
            i3_q      <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            d3_q      <= '0;
            phase_q   <= '0;
            warm_q    <= '0;
            pcm_q     <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            i1_q      <= i1_d;
            i2_q      <= i2_d;
            i3_q      <= i3_d;
            d1_q      <= d1_d;
            d2_q      <= d2_d;
            d3_q      <= d3_d;
            phase_q   <= phase_d;
            warm_q    <= warm_d;
            pcm_q     <= pcm_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign pcm_out   = pcm_q;
    assign out_valid = valid_q;
    assign overrun   = overrun_q;

endmodule
